// File: rtl/fosfor_present_ctrl_if.sv
// fosfor_present_ctrl_if -- handshake and datapath-control bundle for the
// PRESENT block-cipher controller.
//
// Signals (directions as seen by the controller, modport slave):
//   Start_i            in   one-cycle start pulse
//   InValid_i/InReady_o     input nibble stream handshake (key, then plaintext)
//   OutValid_o/OutReady_i   ciphertext nibble stream handshake
//   DpLoadKey_o, DpLoadState_o      datapath shift-in enables
//   DpRound_o, DpFinal_o, DpShiftOut_o  datapath round / final-key-add / shift-out
//   DpRoundCnt_ob5     out  round counter for the key schedule
//   Busy_o, Done_o     out  status
// The master modport is the view of whoever drives the controller.
interface fosfor_present_ctrl_if;
  logic       Start_i;
  logic       InValid_i;
  logic       InReady_o;
  logic       OutValid_o;
  logic       OutReady_i;
  logic       DpLoadKey_o;
  logic       DpLoadState_o;
  logic       DpRound_o;
  logic       DpFinal_o;
  logic       DpShiftOut_o;
  logic [4:0] DpRoundCnt_ob5;
  logic       Busy_o;
  logic       Done_o;

  modport slave (
    input  Start_i, InValid_i, OutReady_i,
    output InReady_o, OutValid_o, DpLoadKey_o, DpLoadState_o, DpRound_o,
           DpFinal_o, DpShiftOut_o, DpRoundCnt_ob5, Busy_o, Done_o
  );

  modport master (
    output Start_i, InValid_i, OutReady_i,
    input  InReady_o, OutValid_o, DpLoadKey_o, DpLoadState_o, DpRound_o,
           DpFinal_o, DpShiftOut_o, DpRoundCnt_ob5, Busy_o, Done_o
  );
endinterface

// File: rtl/fosfor_present_ctrl.sv
// fosfor_present_ctrl -- sequencing FSM for a nibble-serial PRESENT datapath.
//
// Flow: IDLE -> LOAD_KEY (KEY_NIB nibbles) -> LOAD_DATA (16 nibbles)
//       -> ROUND (31 cycles, counter 1..31) -> FINAL (1 cycle)
//       -> UNLOAD (16 nibbles) -> IDLE with a one-cycle Done_o.
//
// Ports:
//   Clk_k     in  clock, all state on the rising edge
//   Reset_rn  in  asynchronous active-low reset
//   bus       fosfor_present_ctrl_if.slave, handshakes and datapath enables
//
// Configuration macro:
//   FOSFOR_PRESENT_KEY128_EN  defined   -> 128-bit key, 32 key nibbles
//                             undefined -> 80-bit key, 20 key nibbles
module fosfor_present_ctrl (
  input  logic                        Clk_k,
  input  logic                        Reset_rn,
  fosfor_present_ctrl_if.slave        bus
);

`ifdef FOSFOR_PRESENT_KEY128_EN
  localparam int KEY_NIB = 32;
`else
  localparam int KEY_NIB = 20;
`endif

  localparam logic [4:0] KEY_LAST  = 5'(KEY_NIB - 1);
  localparam logic [4:0] BLK_LAST  = 5'd15;
  localparam logic [4:0] RND_LAST  = 5'd31;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_KEY,
    S_LOAD_DATA,
    S_ROUND,
    S_FINAL,
    S_UNLOAD
  } state_t;

  state_t     state;
  logic [4:0] nib_cnt;
  logic [4:0] rnd_cnt;
  logic       in_rdy_q;
  logic       out_vld_q;
  logic       round_q;
  logic       final_q;
  logic       busy_q;
  logic       done_q;

  logic       in_xfer;
  logic       out_xfer;

  // Transfers are the only combinational paths: ready/valid are registered,
  // so the load and shift-out enables follow the partner's handshake input
  // within the same cycle.
  assign in_xfer  = bus.InValid_i & in_rdy_q;
  assign out_xfer = out_vld_q & bus.OutReady_i;

  always_ff @(posedge Clk_k or negedge Reset_rn) begin
    if (!Reset_rn) begin
      state     <= S_IDLE;
      nib_cnt   <= '0;
      rnd_cnt   <= '0;
      in_rdy_q  <= 1'b0;
      out_vld_q <= 1'b0;
      round_q   <= 1'b0;
      final_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      // Done is a single-cycle pulse marking the first IDLE cycle.
      done_q <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (bus.Start_i) begin
            state    <= S_LOAD_KEY;
            nib_cnt  <= '0;
            in_rdy_q <= 1'b1;
            busy_q   <= 1'b1;
          end
        end
        S_LOAD_KEY: begin
          if (in_xfer) begin
            if (nib_cnt == KEY_LAST) begin
              state   <= S_LOAD_DATA;
              nib_cnt <= '0;
            end else begin
              nib_cnt <= nib_cnt + 5'd1;
            end
          end
        end
        S_LOAD_DATA: begin
          if (in_xfer) begin
            if (nib_cnt == BLK_LAST) begin
              state    <= S_ROUND;
              nib_cnt  <= '0;
              in_rdy_q <= 1'b0;
              round_q  <= 1'b1;
              rnd_cnt  <= 5'd1;
            end else begin
              nib_cnt <= nib_cnt + 5'd1;
            end
          end
        end
        S_ROUND: begin
          if (rnd_cnt == RND_LAST) begin
            state   <= S_FINAL;
            round_q <= 1'b0;
            final_q <= 1'b1;
          end else begin
            rnd_cnt <= rnd_cnt + 5'd1;
          end
        end
        S_FINAL: begin
          // Round count stays at 31 during FINAL and is cleared on leaving it.
          state     <= S_UNLOAD;
          final_q   <= 1'b0;
          out_vld_q <= 1'b1;
          nib_cnt   <= '0;
          rnd_cnt   <= '0;
        end
        S_UNLOAD: begin
          if (out_xfer) begin
            if (nib_cnt == BLK_LAST) begin
              state     <= S_IDLE;
              nib_cnt   <= '0;
              out_vld_q <= 1'b0;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
            end else begin
              nib_cnt <= nib_cnt + 5'd1;
            end
          end
        end
        default: begin
          state     <= S_IDLE;
          nib_cnt   <= '0;
          rnd_cnt   <= '0;
          in_rdy_q  <= 1'b0;
          out_vld_q <= 1'b0;
          round_q   <= 1'b0;
          final_q   <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.InReady_o      = in_rdy_q;
  assign bus.OutValid_o     = out_vld_q;
  assign bus.DpLoadKey_o    = in_xfer & (state == S_LOAD_KEY);
  assign bus.DpLoadState_o  = in_xfer & (state == S_LOAD_DATA);
  assign bus.DpRound_o      = round_q;
  assign bus.DpFinal_o      = final_q;
  assign bus.DpShiftOut_o   = out_xfer;
  assign bus.DpRoundCnt_ob5 = rnd_cnt;
  assign bus.Busy_o         = busy_q;
  assign bus.Done_o         = done_q;

endmodule
